// File: rtl/wb_stage.sv
// Write-back stage: accepts MEM/WB instructions and selects the write-back
// source (ALU, PC+4 or extended load data). It waits in WAIT_LOAD for the
// data memory response, then drives one register-file write cycle. It also
// counts retired instructions and flags unexpected memory responses.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic [31:0] retire_count,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        is_load;
  logic        load_done;
  logic        reg_write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, handshake and write-enable decode
  always_comb begin
    state_nxt = state;
    in_ready  = (state != WAIT_LOAD);
    accept    = in_valid && (state != WAIT_LOAD);
    is_load   = (in_wb_sel == 2'b01);
    load_done = (state == WAIT_LOAD) && dmem_rvalid;
    RegWrite  = (state == WRITE) && reg_write_q && (rd != '0);
    case (state)
      IDLE, WRITE: begin
        if (accept) state_nxt = is_load ? WAIT_LOAD : WRITE;
        else        state_nxt = IDLE;
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured size/offset
  always_comb begin
    load_byte = dmem_rdata[{addr_lo_q, 3'b000} +: 8];
    load_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = dmem_rdata;
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Instruction capture, write-back data, retire counter and error flag.
  // retire_count steps on the edge entering WRITE, so it already shows the
  // new total during the write cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd           <= '0;
      write_data   <= '0;
      reg_write_q  <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      retire_count <= '0;
      resp_err     <= 1'b0;
    end else begin
      if (accept) begin
        rd          <= in_rd;
        reg_write_q <= in_reg_write;
        funct3_q    <= in_funct3;
        addr_lo_q   <= in_addr_lo;
        if (!is_load)
          write_data <= (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
      end
      if (load_done)
        write_data <= load_data;
      if ((accept && !is_load) || load_done)
        retire_count <= retire_count + 32'd1;
      if (dmem_rvalid && (state != WAIT_LOAD))
        resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected retirements, a
// negedge monitor pops one whenever retire_count moves.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] retire_count;
  logic        resp_err;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
    .retire_count(retire_count), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = '0;
  logic [31:0] prev_cnt = '0;
  logic        hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics computed arithmetically from the word and offset
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) % 32'd256;
    h = (w >> (16 * (a / 2))) % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Monitor: a change of retire_count marks a write-back cycle
  always @(negedge clk) begin
    if (!rst || hold) begin
      prev_cnt = retire_count;
    end else if (retire_count !== prev_cnt) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire actual=%h required=none", retire_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("regwrite", {31'd0, RegWrite}, {31'd0, e.we});
        chk("rd", {27'd0, rd}, {27'd0, e.rd});
        chk("write_data", write_data, e.data);
        chk("retire_count", retire_count, e.cnt);
      end
      prev_cnt = retire_count;
    end else begin
      chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue a non-load (sel 00/10/11); returns #1 after the accepting edge
  task automatic issue_op(input logic [4:0] r, input logic rw, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc);
    exp_t e;
    in_valid = 1'b1; in_rd = r; in_reg_write = rw; in_wb_sel = sel;
    in_alu_result = alu; in_pc_plus4 = pc;
    in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    wait_ready();
    model_cnt = model_cnt + 32'd1;
    e.we = rw && (r != 5'd0); e.rd = r;
    e.data = (sel == 2'b10) ? pc : alu; e.cnt = model_cnt;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Issue a load and answer it after 'waits' stall cycles; noise on in_valid meanwhile
  task automatic issue_load(input logic [4:0] r, input logic rw, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] word,
                            input int unsigned waits);
    exp_t e;
    in_valid = 1'b1; in_rd = r; in_reg_write = rw; in_wb_sel = 2'b01;
    in_funct3 = f3; in_addr_lo = a; in_alu_result = $urandom; in_pc_plus4 = $urandom;
    wait_ready();
    @(posedge clk); #1;
    for (int unsigned i = 0; i < waits; i++) begin
      in_valid = 1'($urandom); in_rd = 5'($urandom); in_wb_sel = 2'($urandom);
      chk("ready_low_wait", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("ready_low_rvalid", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = word;
    model_cnt = model_cnt + 32'd1;
    e.we = rw && (r != 5'd0); e.rd = r; e.data = ld_model(f3, a, word); e.cnt = model_cnt;
    q.push_back(e);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_wb_sel = '0;
    in_alu_result = '0; in_pc_plus4 = '0; in_funct3 = '0; in_addr_lo = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    idle_cycles(2);

    // ALU op to rd 5: write visible the cycle after acceptance
    issue_op(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0);
    chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("alu_data", write_data, 32'h1234_5678);
    chk("alu_retire", retire_count, 32'd1);
    idle_cycles(2);

    // Back-to-back rd 0 then rd 1 with no bubble
    issue_op(5'd0, 1'b1, 2'b00, 32'hAAAA_0000, 32'h0);
    chk("b2b_rd0_regwrite", {31'd0, RegWrite}, 32'd0);
    issue_op(5'd1, 1'b1, 2'b10, 32'h0, 32'h0000_1004);
    chk("b2b_rd1_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("b2b_retire", retire_count, 32'd3);
    idle_cycles(1);

    // Directed loads
    issue_load(5'd7, 1'b1, 3'd0, 2'd2, 32'h0080_0000, 3);
    issue_load(5'd8, 1'b1, 3'd4, 2'd2, 32'h0080_0000, 3);
    issue_load(5'd9, 1'b1, 3'd1, 2'd3, 32'h8001_0000, 1);
    idle_cycles(2);

    // Randomised mix
    for (int unsigned n = 0; n < 150; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      if (kind == 3)
        issue_load(5'($urandom), 1'($urandom), f3s[$urandom_range(0, 7)],
                   2'($urandom), $urandom, $urandom_range(0, 3));
      else
        issue_op(5'($urandom), 1'($urandom),
                 (kind == 0) ? 2'b00 : ((kind == 1) ? 2'b11 : 2'b10),
                 $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(3);
    chk("resp_err_clean", {31'd0, resp_err}, 32'd0);

    // Counter wrap: preload near the top while idle
    @(posedge clk); #2;
    hold = 1'b1;
    force dut.retire_count = 32'hFFFF_FFFE;
    #1 release dut.retire_count;
    model_cnt = 32'hFFFF_FFFE;
    @(negedge clk); @(posedge clk); #1;
    hold = 1'b0;
    issue_op(5'd3, 1'b1, 2'b00, 32'h0000_0033, 32'h0);
    chk("wrap_top", retire_count, 32'hFFFF_FFFF);
    issue_op(5'd4, 1'b1, 2'b00, 32'h0000_0044, 32'h0);
    chk("wrap_zero", retire_count, 32'd0);
    idle_cycles(3);

    begin
      int unsigned n = 0;
      while (q.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
      chk("drain", q.size(), 32'd0);
    end

    // Reset during a pending load, then a stray response
    in_valid = 1'b1; in_rd = 5'd12; in_reg_write = 1'b1; in_wb_sel = 2'b01;
    in_funct3 = 3'd2; in_addr_lo = 2'd0;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pend_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_retire", retire_count, 32'd0);
    chk("mid_rst_rd", {27'd0, rd}, 32'd0);
    chk("mid_rst_data", write_data, 32'd0);
    model_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("stray_resp_err", {31'd0, resp_err}, 32'd1);
    chk("stray_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("stray_retire", retire_count, 32'd0);
    idle_cycles(2);
    chk("resp_err_sticky", {31'd0, resp_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
